// File: rtl/pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// pc_gen_pkg
// Shared definitions for the program-counter unit (the "pc_defs" slice):
//   - redir_sel encodings   : SEL_NONE, SEL_BR, SEL_J, SEL_JR
//   - sequencer states      : ST_BOOT, ST_RUN, ST_FLUSH
//   - default RESET_PC / EXC_PC values
//   - small helpers shared by pc_gen and pc_target
// No ports (package).
// -----------------------------------------------------------------------------
package pc_gen_pkg;

  // Encoding of the redir_sel bus driven by decode/execute.
  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_BR   = 2'b01,
    SEL_J    = 2'b10,
    SEL_JR   = 2'b11
  } redir_sel_e;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_PC   = 32'h0000_4180;

  // Byte distance between consecutive instruction words.
  localparam logic [31:0] PC_STEP = 32'd4;

  // Bubble counter width; FLUSH_CYC is limited to 0..3.
  localparam int FLUSH_CNT_W = 2;

  // A word address must have its two low bits clear.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/pc_gen_target.sv
// -----------------------------------------------------------------------------
// pc_target
// Purely combinational redirect calculator: decides whether a resolved control
// instruction redirects fetch and which address it redirects to. Kept separate
// so a branch-predictor block can reuse the same target arithmetic.
//
// Parameters:
//   WIDTH        PC/address width (>= 28)
// Ports:
//   redir_valid  in   control instruction resolved this cycle
//   redir_sel    in   2-bit redirect kind (see redir_sel_e)
//   redir_base   in   PC of the control instruction
//   br_taken     in   branch condition true
//   br_imm       in   signed branch offset in words
//   j_imm        in   26-bit jump index
//   jr_target    in   register-jump target
//   link_addr    out  redir_base + 4
//   target       out  selected redirect target (raw, unchecked)
//   redir_taken  out  a redirect applies this cycle
// All arithmetic wraps modulo 2^WIDTH.
// -----------------------------------------------------------------------------
module pc_target
  import pc_gen_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             redir_valid,
  input  logic [1:0]       redir_sel,
  input  logic [WIDTH-1:0] redir_base,
  input  logic             br_taken,
  input  logic [15:0]      br_imm,
  input  logic [25:0]      j_imm,
  input  logic [WIDTH-1:0] jr_target,
  output logic [WIDTH-1:0] link_addr,
  output logic [WIDTH-1:0] target,
  output logic             redir_taken
);

  redir_sel_e       sel;
  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;

  assign sel       = redir_sel_e'(redir_sel);
  assign link_addr = redir_base + WIDTH'(PC_STEP);

  // Word offset sign-extended to WIDTH and scaled to bytes.
  assign br_off    = {{(WIDTH-18){br_imm[15]}}, br_imm, 2'b00};
  assign br_target = link_addr + br_off;

  // The jump keeps the region bits of the delay-slot address (link_addr);
  // with WIDTH == 28 there is no region and the index fills the PC.
  if (WIDTH > 28) begin : g_j_region
    assign j_target = {link_addr[WIDTH-1:28], j_imm, 2'b00};
  end else begin : g_j_flat
    assign j_target = {j_imm, 2'b00};
  end

  always_comb begin
    target      = link_addr;
    redir_taken = 1'b0;
    case (sel)
      SEL_BR: begin
        target      = br_target;
        redir_taken = redir_valid & br_taken;
      end
      SEL_J: begin
        target      = j_target;
        redir_taken = redir_valid;
      end
      SEL_JR: begin
        target      = jr_target;
        redir_taken = redir_valid;
      end
      default: begin
        target      = link_addr;
        redir_taken = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
// Program-counter unit: owns the PC register, applies redirects from the
// decode/execute path, inserts post-redirect bubbles and issues instruction
// fetch requests to the instruction memory.
//
// Build option: define PC_ALIGN_CHECK_EN to trap misaligned redirect targets
// to EXC_PC and pulse align_err for one cycle. Without it targets load
// unchecked, jr targets have bits [1:0] cleared, and align_err stays 0.
//
// Parameters:
//   WIDTH      PC/address width (>= 28)
//   RESET_PC   PC after reset (truncated to WIDTH)
//   FLUSH_CYC  bubble cycles after a redirect (0..3)
//   EXC_PC     trap target for a misaligned redirect (align check builds)
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   stall        hold PC and sequencer state
//   if_ready     instruction memory accepts the request
//   fetch_valid  fetch request valid (registered)
//   fetch_pc     fetch address (the PC register)
//   redir_*      redirect request from decode/execute (see pc_target)
//   br_taken, br_imm, j_imm, jr_target   target operands
//   link_addr    redir_base + 4 for link writeback (combinational)
//   redir_taken  redirect applied this cycle (combinational)
//   align_err    one-cycle misaligned-target flag (registered)
//   dbg_state    current sequencer state, for observation only
//
// Fetch handshake: a request transfers on a rising edge where
// fetch_valid && if_ready, no stall and no redirect; once raised,
// fetch_valid and fetch_pc stay stable until that transfer or a redirect.
// A redirect wins over a same-cycle transfer, which is then dropped.
// -----------------------------------------------------------------------------
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          FLUSH_CYC = 1,
  parameter logic [31:0] EXC_PC    = DEFAULT_EXC_PC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             if_ready,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] fetch_pc,
  input  logic             redir_valid,
  input  logic [1:0]       redir_sel,
  input  logic [WIDTH-1:0] redir_base,
  input  logic             br_taken,
  input  logic [15:0]      br_imm,
  input  logic [25:0]      j_imm,
  input  logic [WIDTH-1:0] jr_target,
  output logic [WIDTH-1:0] link_addr,
  output logic             redir_taken,
  output logic             align_err,
  output pc_state_e        dbg_state
);

  localparam logic [WIDTH-1:0]       RST_PC_W   = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0]       STEP_W     = WIDTH'(PC_STEP);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYC);

  // Reject parameter sets the datapath cannot represent.
  if (WIDTH < 28 || FLUSH_CYC < 0 || FLUSH_CYC > 3 || EXC_PC[1:0] != 2'b00)
  begin : g_param_check
    $error("pc_gen: illegal WIDTH, FLUSH_CYC or EXC_PC");
  end

  // ---------------------------------------------------------------------------
  // Redirect target
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] load_pc;
  logic             target_bad;

  pc_target #(
    .WIDTH (WIDTH)
  ) u_target (
    .redir_valid (redir_valid),
    .redir_sel   (redir_sel),
    .redir_base  (redir_base),
    .br_taken    (br_taken),
    .br_imm      (br_imm),
    .j_imm       (j_imm),
    .jr_target   (jr_target),
    .link_addr   (link_addr),
    .target      (target),
    .redir_taken (redir_taken)
  );

`ifdef PC_ALIGN_CHECK_EN
  // Any redirect kind may be misaligned (a bad redir_base skews branch and
  // jump targets too), so the check covers the selected target.
  assign target_bad = is_misaligned(target[1:0]);
  assign load_pc    = target_bad ? WIDTH'(EXC_PC) : target;
`else
  // Only jr takes an arbitrary register value; its low bits are dropped so
  // fetch always sees a word address.
  assign target_bad = 1'b0;
  assign load_pc    = (redir_sel == SEL_JR) ? {target[WIDTH-1:2], 2'b00}
                                            : target;
`endif

  // ---------------------------------------------------------------------------
  // PC register and fetch sequencer
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]       pc;
  pc_state_e              state;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic                   align_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RST_PC_W;
      state       <= ST_BOOT;
      flush_cnt   <= '0;
      fetch_valid <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      // The flag only lives for the cycle after the trapped redirect.
      align_err_q <= 1'b0;

      if (redir_taken) begin
        // Redirect beats stall and any same-cycle fetch transfer.
        pc          <= load_pc;
        align_err_q <= target_bad;
        if (FLUSH_CYC > 0) begin
          state       <= ST_FLUSH;
          flush_cnt   <= FLUSH_INIT;
          fetch_valid <= 1'b0;
        end else begin
          state       <= ST_RUN;
          flush_cnt   <= '0;
          fetch_valid <= 1'b1;
        end
      end else if (!stall) begin
        case (state)
          ST_BOOT: begin
            state       <= ST_RUN;
            fetch_valid <= 1'b1;
          end
          ST_RUN: begin
            fetch_valid <= 1'b1;
            if (if_ready) begin
              pc <= pc + STEP_W;
            end
          end
          ST_FLUSH: begin
            // Leave on the cycle the count would hit zero, so exactly
            // FLUSH_CYC bubbles are seen on fetch_valid.
            flush_cnt <= flush_cnt - 1'b1;
            if (flush_cnt <= FLUSH_CNT_W'(1)) begin
              state       <= ST_RUN;
              fetch_valid <= 1'b1;
            end
          end
          default: begin
            state       <= ST_BOOT;
            flush_cnt   <= '0;
            fetch_valid <= 1'b0;
          end
        endcase
      end
      // stall without redirect: pc, state and flush_cnt hold.
    end
  end

  assign fetch_pc  = pc;
  assign align_err = align_err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen
// Directed bench for pc_gen. u_dut1 (FLUSH_CYC=1) runs a table of vectors;
// u_dut2 (FLUSH_CYC=2) shares the same inputs and covers the two-bubble
// flush and an asynchronous reset inside a flush.
// -----------------------------------------------------------------------------
module tb_pc_gen;
  import pc_gen_pkg::*;

  localparam int W = 32;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         stall, if_ready, redir_valid, br_taken;
  logic [1:0]   redir_sel;
  logic [W-1:0] redir_base, jr_target;
  logic [15:0]  br_imm;
  logic [25:0]  j_imm;

  logic         fv1, taken1, aerr1;
  logic [W-1:0] fpc1, link1;
  pc_state_e    st1;
  logic         fv2, taken2, aerr2;
  logic [W-1:0] fpc2, link2;
  pc_state_e    st2;

  pc_gen #(.WIDTH(W), .RESET_PC(32'h0000_3000), .FLUSH_CYC(1),
           .EXC_PC(32'h0000_4180)) u_dut1 (
    .clk(clk), .rst(rst), .stall(stall), .if_ready(if_ready),
    .fetch_valid(fv1), .fetch_pc(fpc1), .redir_valid(redir_valid),
    .redir_sel(redir_sel), .redir_base(redir_base), .br_taken(br_taken),
    .br_imm(br_imm), .j_imm(j_imm), .jr_target(jr_target),
    .link_addr(link1), .redir_taken(taken1), .align_err(aerr1),
    .dbg_state(st1)
  );

  pc_gen #(.WIDTH(W), .RESET_PC(32'h0000_3000), .FLUSH_CYC(2),
           .EXC_PC(32'h0000_4180)) u_dut2 (
    .clk(clk), .rst(rst), .stall(stall), .if_ready(if_ready),
    .fetch_valid(fv2), .fetch_pc(fpc2), .redir_valid(redir_valid),
    .redir_sel(redir_sel), .redir_base(redir_base), .br_taken(br_taken),
    .br_imm(br_imm), .j_imm(j_imm), .jr_target(jr_target),
    .link_addr(link2), .redir_taken(taken2), .align_err(aerr2),
    .dbg_state(st2)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle(input logic rdy);
    stall       = 1'b0;
    if_ready    = rdy;
    redir_valid = 1'b0;
    redir_sel   = 2'b00;
    redir_base  = '0;
    br_taken    = 1'b0;
    br_imm      = '0;
    j_imm       = '0;
    jr_target   = '0;
  endtask

  task automatic drive_jr(input logic [W-1:0] tgt);
    redir_valid = 1'b1;
    redir_sel   = 2'b11;
    jr_target   = tgt;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         stall;
    logic         rdy;
    logic         rv;
    logic [1:0]   sel;
    logic [W-1:0] base;
    logic         bt;
    logic [15:0]  bimm;
    logic [25:0]  jimm;
    logic [W-1:0] jr;
    logic         e_taken;
    logic [W-1:0] e_link;
    logic [W-1:0] e_pc;
    logic         e_valid;
    logic         e_aerr;
  } vec_t;

  function automatic vec_t mk(
    input logic stl, input logic rdy, input logic rv, input logic [1:0] sel,
    input logic [W-1:0] base, input logic bt, input logic [15:0] bimm,
    input logic [25:0] jimm, input logic [W-1:0] jr,
    input logic e_taken, input logic [W-1:0] e_link, input logic [W-1:0] e_pc,
    input logic e_valid, input logic e_aerr);
    vec_t v;
    v.stall = stl;  v.rdy = rdy;   v.rv = rv;     v.sel = sel;
    v.base = base;  v.bt = bt;     v.bimm = bimm; v.jimm = jimm;
    v.jr = jr;      v.e_taken = e_taken;          v.e_link = e_link;
    v.e_pc = e_pc;  v.e_valid = e_valid;          v.e_aerr = e_aerr;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [W-1:0] trap_pc;
    logic [W-1:0] exp_pc;
    trap_pc = ALIGN_ON ? 32'h0000_4180 : 32'h0000_3100;

    // stall rdy rv sel base bt bimm jimm jr | taken link pc valid aerr
    vecs.push_back(mk(0,1,0,2'b00,'0,0,'0,'0,'0, 0,32'h4, 32'h3000,1,0));
    vecs.push_back(mk(0,1,0,2'b00,'0,0,'0,'0,'0, 0,32'h4, 32'h3004,1,0));
    vecs.push_back(mk(0,1,0,2'b00,'0,0,'0,'0,'0, 0,32'h4, 32'h3008,1,0));
    // stall with if_ready high: frozen, still valid
    vecs.push_back(mk(1,1,0,2'b00,'0,0,'0,'0,'0, 0,32'h4, 32'h3008,1,0));
    vecs.push_back(mk(1,1,0,2'b00,'0,0,'0,'0,'0, 0,32'h4, 32'h3008,1,0));
    vecs.push_back(mk(1,1,0,2'b00,'0,0,'0,'0,'0, 0,32'h4, 32'h3008,1,0));
    // jr during stall takes effect, then stall holds it (flush count held)
    vecs.push_back(mk(1,1,1,2'b11,'0,0,'0,'0,32'h3100, 1,32'h4, 32'h3100,0,0));
    vecs.push_back(mk(1,1,0,2'b00,'0,0,'0,'0,'0, 0,32'h4, 32'h3100,0,0));
    vecs.push_back(mk(0,1,0,2'b00,'0,0,'0,'0,'0, 0,32'h4, 32'h3100,1,0));
    vecs.push_back(mk(0,1,0,2'b00,'0,0,'0,'0,'0, 0,32'h4, 32'h3104,1,0));
    // taken backward branch
    vecs.push_back(mk(0,1,1,2'b01,32'h3010,1,16'hFFFC,'0,'0, 1,32'h3014, 32'h3004,0,0));
    vecs.push_back(mk(0,1,0,2'b00,'0,0,'0,'0,'0, 0,32'h4, 32'h3004,1,0));
    vecs.push_back(mk(0,1,0,2'b00,'0,0,'0,'0,'0, 0,32'h4, 32'h3008,1,0));
    // jump across the 256MB region boundary
    vecs.push_back(mk(0,1,1,2'b10,32'h3FFF_FFFC,0,'0,26'h10,'0, 1,32'h4000_0000, 32'h4000_0040,0,0));
    vecs.push_back(mk(0,1,0,2'b00,'0,0,'0,'0,'0, 0,32'h4, 32'h4000_0040,1,0));
    // not-taken branch and sel=00 are not redirects
    vecs.push_back(mk(0,1,1,2'b01,32'h3FFF_FFFC,0,'0,26'h10,'0, 0,32'h4000_0000, 32'h4000_0044,1,0));
    vecs.push_back(mk(0,1,1,2'b00,'0,0,'0,'0,'0, 0,32'h4, 32'h4000_0048,1,0));
    // memory not ready: hold
    vecs.push_back(mk(0,0,0,2'b00,'0,0,'0,'0,'0, 0,32'h4, 32'h4000_0048,1,0));
    // wrap from all-ones to zero
    vecs.push_back(mk(0,1,1,2'b11,'0,0,'0,'0,32'hFFFF_FFF8, 1,32'h4, 32'hFFFF_FFF8,0,0));
    vecs.push_back(mk(0,1,0,2'b00,'0,0,'0,'0,'0, 0,32'h4, 32'hFFFF_FFF8,1,0));
    vecs.push_back(mk(0,1,0,2'b00,'0,0,'0,'0,'0, 0,32'h4, 32'hFFFF_FFFC,1,0));
    vecs.push_back(mk(0,1,0,2'b00,'0,0,'0,'0,'0, 0,32'h4, 32'h0000_0000,1,0));
    // misaligned jr target
    vecs.push_back(mk(0,1,1,2'b11,'0,0,'0,'0,32'h3102, 1,32'h4, trap_pc,0,ALIGN_ON));
    vecs.push_back(mk(0,1,0,2'b00,'0,0,'0,'0,'0, 0,32'h4, trap_pc,1,0));
    // sel=jr without redir_valid is ignored
    vecs.push_back(mk(0,1,0,2'b11,'0,0,'0,'0,32'h5000, 0,32'h4, trap_pc + 32'h4,1,0));

    foreach (vecs[i]) exp_q.push_back(vecs[i].e_pc);

    // ---- reset ----
    drive_idle(1'b1);
    rst = 1'b1;
    step();
    step();
    check("rst_valid", 64'(fv1), 64'h0);
    check("rst_pc", 64'(fpc1), 64'h3000);
    check("rst_aerr", 64'(aerr1), 64'h0);
    check("rst_state", 64'(st1), 64'(ST_BOOT));
    rst = 1'b0;
    #1;
    check("boot_valid", 64'(fv1), 64'h0);

    // ---- table on u_dut1 ----
    for (int i = 0; i < vecs.size(); i++) begin
      stall       = vecs[i].stall;
      if_ready    = vecs[i].rdy;
      redir_valid = vecs[i].rv;
      redir_sel   = vecs[i].sel;
      redir_base  = vecs[i].base;
      br_taken    = vecs[i].bt;
      br_imm      = vecs[i].bimm;
      j_imm       = vecs[i].jimm;
      jr_target   = vecs[i].jr;
      #1;
      check($sformatf("v%0d_taken", i), 64'(taken1), 64'(vecs[i].e_taken));
      check($sformatf("v%0d_link", i), 64'(link1), 64'(vecs[i].e_link));
      step();
      exp_pc = exp_q.pop_front();
      check($sformatf("v%0d_pc", i), 64'(fpc1), 64'(exp_pc));
      check($sformatf("v%0d_valid", i), 64'(fv1), 64'(vecs[i].e_valid));
      check($sformatf("v%0d_aerr", i), 64'(aerr1), 64'(vecs[i].e_aerr));
    end

    // ---- u_dut2: FLUSH_CYC=2, redirect beats handshake ----
    drive_idle(1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("d2_run_pc", 64'(fpc2), 64'h3000);
    check("d2_run_valid", 64'(fv2), 64'h1);
    step();
    check("d2_seq_pc", 64'(fpc2), 64'h3004);
    drive_jr(32'h3200);
    #1;
    check("d2_taken", 64'(taken2), 64'h1);
    step();
    check("d2_redir_pc", 64'(fpc2), 64'h3200);
    check("d2_flush1_valid", 64'(fv2), 64'h0);
    check("d2_flush1_state", 64'(st2), 64'(ST_FLUSH));
    drive_idle(1'b1);
    step();
    check("d2_flush2_valid", 64'(fv2), 64'h0);
    check("d2_flush2_pc", 64'(fpc2), 64'h3200);
    step();
    check("d2_resume_valid", 64'(fv2), 64'h1);
    check("d2_resume_pc", 64'(fpc2), 64'h3200);
    step();
    check("d2_next_pc", 64'(fpc2), 64'h3204);

    // ---- u_dut2: async reset in the second flush cycle ----
    drive_jr(32'h3300);
    step();
    drive_idle(1'b1);
    step();
    check("d2_rf_flush2_valid", 64'(fv2), 64'h0);
    check("d2_rf_flush2_pc", 64'(fpc2), 64'h3300);
    #2;
    rst = 1'b1;
    #1;
    check("d2_async_pc", 64'(fpc2), 64'h3000);
    check("d2_async_state", 64'(st2), 64'(ST_BOOT));
    check("d2_async_valid", 64'(fv2), 64'h0);
    #1;
    rst = 1'b0;
    step();
    check("d2_after_rst_valid", 64'(fv2), 64'h1);
    check("d2_after_rst_pc", 64'(fpc2), 64'h3000);

    // ---- final report ----
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program-counter unit: owns the PC register, computes sequential, branch, jump and register-jump targets, and drives the instruction-fetch request with a valid/ready handshake.
- Supports stall and post-redirect flush bubbles.
- Sits between the decode/execute control path, which supplies redirects, and the instruction memory port.

Parameters:
- WIDTH, 32, PC/address width (>=28).
- RESET_PC, 32'h0000_3000, PC loaded on reset (truncated to WIDTH).
- FLUSH_CYC, 1, bubble cycles with fetch_valid low after a redirect (0..3).
- EXC_PC, 32'h0000_4180, target used on misaligned redirect (feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC; fetch_valid stays asserted with unchanged fetch_pc.
- if_ready  in  1  instruction memory accepts request.
- fetch_valid  out  1  fetch request valid.
- fetch_pc  out  WIDTH  address of request (registered PC).
- redir_valid  in  1  control instruction resolved this cycle.
- redir_sel  in  2  00 none, 01 branch, 10 jump, 11 jr.
- redir_base  in  WIDTH  PC of the control instruction.
- br_taken  in  1  branch condition true.
- br_imm  in  16  branch offset (words, signed).
- j_imm  in  26  jump index.
- jr_target  in  WIDTH  register-jump target.
- link_addr  out  WIDTH  redir_base+4 (combinational, for jal/jalr writeback).
- redir_taken  out  1  a redirect is applied this cycle (combinational).
- align_err  out  1  registered misaligned-target flag (0 when feature off).

Behaviour:
- Reset (async): pc=RESET_PC, state=BOOT, flush_cnt=0, align_err=0; fetch_valid=0.
- FSM states BOOT, RUN, FLUSH.
  - BOOT: one cycle, fetch_valid=0, then RUN.
  - RUN: fetch_valid=1.
  - FLUSH: fetch_valid=0; flush_cnt decrements each cycle; return to RUN when it would reach 0.
- Targets, all arithmetic mod 2^WIDTH:
  - Branch: redir_base+4 + (sext(br_imm)<<2).
  - Jump: {(redir_base+4)[WIDTH-1:28], j_imm, 2'b00}.
  - jr: jr_target.
- redir_taken = redir_valid & (sel==10 | sel==11 | (sel==01 & br_taken)). sel==00, or a not-taken branch, behaves as no redirect.
- Priority each cycle: redirect > stall > handshake.
  - Redirect: pc<=target next edge in any state (including BOOT and FLUSH). Enter FLUSH with flush_cnt=FLUSH_CYC if FLUSH_CYC>0, else RUN. Any handshake in that cycle is discarded.
  - Else stall=1: pc and state held; FLUSH count still held.
  - Else in RUN with if_ready=1: pc<=pc+4 (wraps from all-ones to 0).
  - Else: hold.
- Latency: target visible on fetch_pc one cycle after redir_taken; fetch_valid returns FLUSH_CYC cycles later.
- Redirect arriving during stall still takes effect; stall then holds the new PC.
- Reset mid-FLUSH returns to BOOT immediately.

Optional Feature:
- PC_ALIGN_CHECK_EN defined: if a taken redirect target has [1:0]!=0, pc<=EXC_PC instead. align_err=1 for exactly one cycle (registered), then clears. FSM flushes as normal.
- Undefined: targets loaded unchecked, bits [1:0] forced to 0 on jr, align_err tied 0.

Decomposition:
- Shared package/header pc_defs holds:
  - redir_sel encodings (SEL_NONE, SEL_BR, SEL_J, SEL_JR).
  - FSM state encodings (ST_BOOT, ST_RUN, ST_FLUSH).
  - Default RESET_PC and EXC_PC.
- One natural sub-module: pc_target, the purely combinational target/redir_taken calculator, reused by a future branch-predictor block.

Test Plan:
- Reset with FLUSH_CYC=1, if_ready=1 -> fetch_valid=0 in cycle 0; then fetch_pc 0x3000, 0x3004, 0x3008 on successive cycles.
- Taken branch, redir_base=0x3010, br_imm=16'hFFFC -> fetch_pc=0x3004 next cycle; fetch_valid low 1 cycle, then high.
- Jump, redir_base=0x3FFFFFFC, j_imm=26'h0000010 -> fetch_pc=0x40000040. Same stimulus with br_taken=0 and sel=01 -> no redirect, sequential +4 continues.
- stall=1 with if_ready=1 for 3 cycles -> fetch_pc frozen at 0x3008, fetch_valid=1. Redirect jr 0x3100 during stall -> fetch_pc=0x3100 next cycle, still held.
- Redirect and if_ready in the same cycle, FLUSH_CYC=2 -> pc=target (not pc+4); fetch_valid low exactly 2 cycles. Async rst pulse in the 2nd flush cycle -> fetch_pc=0x3000 immediately, BOOT.
- PC_ALIGN_CHECK_EN, jr_target=0x3102 -> fetch_pc=0x4180, align_err high one cycle. Without the macro -> fetch_pc=0x3100, align_err=0.
